// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only bus driver.
// Holds the FSM state encoding, RS encodings, long-latency opcodes and the init sequence.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_LOAD,
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam logic RS_ADDR = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // 8-bit bus, 2 lines, 5x8 font; display on; clear; increment without shift
  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
  localparam logic [7:0] INIT_CLEAR    = 8'h01;
  localparam logic [7:0] INIT_ENTRY    = 8'h06;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return (rs == RS_ADDR) && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Upstream byte handshake into the LCD driver: strobe, RS select, byte, and lock back-pressure.
interface lcd_bus_driver_if;
  logic       write;
  logic       addrOrData;
  logic [7:0] lcdBus;
  logic       busLock;

  modport master (output write, output addrOrData, output lcdBus, input busLock);
  modport slave  (input write, input addrOrData, input lcdBus, output busLock);
endinterface

// File: rtl/lcd_init_rom.sv
// Combinational table of the four power-on init commands; last flags the final entry.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [1:0] idx,
  output logic [7:0] cmd,
  output logic       last
);

  always_comb begin
    cmd  = INIT_FUNC_SET;
    last = 1'b0;
    case (idx)
      2'd0: cmd = INIT_FUNC_SET;
      2'd1: cmd = INIT_DISP_ON;
      2'd2: cmd = INIT_CLEAR;
      2'd3: begin
        cmd  = INIT_ENTRY;
        last = 1'b1;
      end
      default: cmd = INIT_FUNC_SET;
    endcase
  end

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only driver: power-up delay, fixed init sequence, then one byte per upstream write.
// A single down-counter times every state; loading N keeps the FSM in that state for N cycles.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 2000000,
  parameter int SETUP_CYC      = 4,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000
)(
  input  logic             clk,
  input  logic             rst,
  lcd_bus_driver_if.slave  bus,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_e,
  output logic [7:0]       lcd_data
);

  localparam int MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
  localparam int MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LD_POWERUP = cnt_t'(POWERUP_CYC);
  localparam cnt_t LD_SETUP   = cnt_t'(SETUP_CYC);
  localparam cnt_t LD_E_HIGH  = cnt_t'(E_HIGH_CYC);
  localparam cnt_t LD_HOLD    = cnt_t'(HOLD_CYC);
  localparam cnt_t LD_CMD     = cnt_t'(CMD_WAIT_CYC);
  localparam cnt_t LD_CLEAR   = cnt_t'(CLEAR_WAIT_CYC);

  lcd_state_t state_reg, state_next;
  cnt_t       cnt_reg, cnt_next;
  logic [1:0] idx_reg, idx_next;
  logic       init_reg, init_next;
  logic       last_reg, last_next;
  logic       rs_reg, rs_next;
  logic [7:0] data_reg, data_next;

  logic [7:0] rom_cmd;
  logic       rom_last;
  logic       cnt_done;
  cnt_t       cnt_dec;

  lcd_init_rom u_init_rom (
    .idx  (idx_reg),
    .cmd  (rom_cmd),
    .last (rom_last)
  );

  assign cnt_done = (cnt_reg == cnt_t'(1));
  assign cnt_dec  = cnt_reg - cnt_t'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_POWERUP;
      cnt_reg   <= LD_POWERUP;
      idx_reg   <= 2'd0;
      init_reg  <= 1'b1;
      last_reg  <= 1'b0;
      rs_reg    <= RS_ADDR;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      init_reg  <= init_next;
      last_reg  <= last_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
    end
  end

  // RS/data are only ever loaded on the transition into SETUP, so they are frozen across E.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    init_next  = init_reg;
    last_next  = last_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    case (state_reg)
      ST_POWERUP: begin
        if (cnt_done) state_next = ST_INIT_LOAD;
        else          cnt_next   = cnt_dec;
      end
      ST_INIT_LOAD: begin
        rs_next    = RS_ADDR;
        data_next  = rom_cmd;
        last_next  = rom_last;
        idx_next   = idx_reg + 2'd1;
        state_next = ST_SETUP;
        cnt_next   = LD_SETUP;
      end
      ST_IDLE: begin
        if (bus.write) begin
          rs_next    = bus.addrOrData;
          data_next  = bus.lcdBus;
          state_next = ST_SETUP;
          cnt_next   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_next = ST_E_HIGH;
          cnt_next   = LD_E_HIGH;
        end else cnt_next = cnt_dec;
      end
      ST_E_HIGH: begin
        if (cnt_done) begin
          state_next = ST_HOLD;
          cnt_next   = LD_HOLD;
        end else cnt_next = cnt_dec;
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_next = ST_WAIT;
          cnt_next   = is_long_cmd(rs_reg, data_reg) ? LD_CLEAR : LD_CMD;
        end else cnt_next = cnt_dec;
      end
      ST_WAIT: begin
        if (cnt_done) begin
          if (init_reg && !last_reg) begin
            state_next = ST_INIT_LOAD;
          end else begin
            init_next  = 1'b0;
            state_next = ST_IDLE;
          end
        end else cnt_next = cnt_dec;
      end
      default: begin
        state_next = ST_POWERUP;
        cnt_next   = LD_POWERUP;
      end
    endcase
  end

  assign lcd_e       = (state_reg == ST_E_HIGH);
  assign lcd_rw      = 1'b0;
  assign lcd_rs      = rs_reg;
  assign lcd_data    = data_reg;
  assign bus.busLock = (state_reg != ST_IDLE);

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 SHALL have parameter POWERUP_CYC, 2000000, clk cycles waited after reset before the first init command (40 ms @ 50 MHz).
REQ-002 SHALL have parameter SETUP_CYC, 4, cycles RS/RW/data are stable before E rises.
REQ-003 SHALL have parameter E_HIGH_CYC, 12, cycles E is held high.
REQ-004 SHALL have parameter HOLD_CYC, 2, cycles RS/RW/data are held after E falls.
REQ-005 SHALL have parameter CMD_WAIT_CYC, 2500, post-hold busy time for an ordinary command or data byte.
REQ-006 SHALL have parameter CLEAR_WAIT_CYC, 82000, post-hold busy time for command 0x01 or 0x02.
REQ-007 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port write, input, 1, upstream strobe: byte on lcdBus is valid this cycle.
REQ-010 SHALL have port addrOrData, input, 1, 0 = command/address byte (RS=0), 1 = data byte (RS=1).
REQ-011 SHALL have port lcdBus, input, 8, the byte to transfer.
REQ-012 SHALL have port busLock, output, 1, 1 = locked/busy, 0 = ready to accept.
REQ-013 SHALL have ports lcd_rs, lcd_rw, lcd_e, output, 1 each, HD44780 control pins.
REQ-014 SHALL have port lcd_data, output, 8, HD44780 data pins.

Function
REQ-015 SHALL implement states POWERUP, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD, WAIT.
REQ-016 POWERUP: count POWERUP_CYC cycles, then INIT_LOAD.
REQ-017 INIT_LOAD: latch the next init command (0x38, 0x0C, 0x01, 0x06, in order) with RS=0, go to SETUP; after the fourth command's WAIT, go to IDLE.
REQ-018 IDLE: busLock=0; on write=1, latch lcdBus and addrOrData, go to SETUP next cycle; busLock=1 from that edge onward.
REQ-019 SETUP: lcd_rs/lcd_data drive latched values, lcd_e=0, for exactly SETUP_CYC cycles, then E_HIGH.
REQ-020 E_HIGH: lcd_e=1 for exactly E_HIGH_CYC cycles, then HOLD.
REQ-021 HOLD: lcd_e=0, lcd_rs/lcd_data unchanged, HOLD_CYC cycles, then WAIT.
REQ-022 WAIT: count CLEAR_WAIT_CYC if latched RS=0 and byte is 0x01 or 0x02, else CMD_WAIT_CYC; then IDLE (or INIT_LOAD during init).
REQ-023 lcd_rw SHALL be constantly 0 (write-only; no busy-flag read).
REQ-024 busLock SHALL be 1 in every state except IDLE.
REQ-025 write while busLock=1 SHALL be ignored, with no latching and no queuing.
REQ-026 lcd_data/lcd_rs SHALL change only on the SETUP entry edge; never while lcd_e=1.
REQ-027 Single shared down-counter SHALL be sized $clog2(max parameter)+1 bits; loading N yields exactly N cycles in state.
REQ-028 Byte transfer latency: write accepted at cycle 0, lcd_e rises at cycle 1+SETUP_CYC.

Reset
REQ-029 With rst=1 at a clock edge: state=POWERUP, counter=POWERUP_CYC, init index=0, busLock=1, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00.
REQ-030 Reset mid-transfer (incl. E_HIGH) SHALL drop lcd_e at that edge and restart the full power-up/init sequence.

Structure
REQ-031 Shared package lcd_pkg SHALL hold the state typedef, RS encodings (addr=0, data=1), clear/home opcodes, and init command constants.
REQ-032 The init command table SHALL be sub-module lcd_init_rom (2-bit index in, 8-bit command and last flag out, combinational).

Verification (override params: POWERUP 20, SETUP 2, E_HIGH 3, HOLD 1, CMD_WAIT 5, CLEAR_WAIT 15)
REQ-033 Release rst -> busLock=1 for 20 cycles, then four E pulses with lcd_data 0x38, 0x0C, 0x01, 0x06, RS=0, each E high exactly 3 cycles; 0x01 is followed by a 15-cycle gap; then busLock=0.
REQ-034 In IDLE, write, addrOrData=1, lcdBus=0x41 -> next cycle busLock=1, lcd_rs=1, lcd_data=0x41; lcd_e high on cycles 3-5; busLock=0 after 1+2+3+1+5 cycles.
REQ-035 write, addrOrData=0, lcdBus=0x01 -> RS=0, WAIT lasts 15 cycles; with lcdBus=0x80 -> WAIT lasts 5 cycles.
REQ-036 write pulsed with lcdBus=0x55 during an ongoing transfer -> 0x55 never appears on lcd_data; the first transfer completes unchanged.
REQ-037 rst asserted during E_HIGH -> lcd_e=0 and busLock=1 at that edge; after release, the full init sequence replays from 0x38.
REQ-038 Checker over all tests: lcd_data/lcd_rs never change while lcd_e=1; lcd_rw always 0.
